mult_div_unit: RTL



---
 rtl/md_pkg.sv | 17 +
 rtl/mult_div_unit.sv | 119 +++++++++++
 2 files changed

// File: rtl/md_pkg.sv
// Shared encodings and defaults for the iterative multiply/divide unit.
package md_pkg;

  localparam int MD_WIDTH = 32;

  localparam logic MD_MULT = 1'b0;
  localparam logic MD_DIV  = 1'b1;

  // The bare MD_MULT/MD_DIV names are the op encodings, so the busy states carry an _ST suffix.
  typedef enum logic [1:0] {
    MD_IDLE    = 2'd0,
    MD_MULT_ST = 2'd1,
    MD_DIV_ST  = 2'd2,
    MD_FIX     = 2'd3
  } md_state_e;

endpackage

// File: rtl/mult_div_unit.sv
// Iterative signed mult/div: magnitudes in, one bit per cycle, sign fix-up, then HI/LO write.
module mult_div_unit
  import md_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             divby0flag
);

  localparam int CW = $clog2(WIDTH);

  md_state_e          state_q;
  logic [CW-1:0]      cnt_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [WIDTH-1:0]   opnd_q;
  logic [WIDTH-1:0]   rem_q;
  logic               op_q, neg_lo_q, neg_hi_q;
  logic               busy_q, done_q, flag_q;
  logic [WIDTH-1:0]   hi_q, lo_q;

  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     mul_sum, div_shift, div_trial;
  logic [WIDTH-1:0]   lo_fix, prod_hi_fix, rem_fix;

  function automatic logic [WIDTH-1:0] cneg(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? (~v + {{(WIDTH-1){1'b0}}, 1'b1}) : v;
  endfunction

  always_comb begin
    mag_a     = cneg(a, a[WIDTH-1]);
    mag_b     = cneg(b, b[WIDTH-1]);
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    div_shift = {rem_q, acc_q[WIDTH-1]};
    div_trial = div_shift - {1'b0, opnd_q};
    lo_fix    = cneg(acc_q[WIDTH-1:0], neg_lo_q);
    // Upper half of a 2W negation borrows one less whenever the lower half is non-zero.
    prod_hi_fix = cneg(acc_q[2*WIDTH-1:WIDTH], neg_lo_q)
                - {{(WIDTH-1){1'b0}}, neg_lo_q & (|acc_q[WIDTH-1:0])};
    rem_fix   = cneg(rem_q, neg_hi_q);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= MD_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      rem_q    <= '0;
      op_q     <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      flag_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        MD_IDLE: begin
          if (start) begin
            if (op == MD_DIV && b == '0) begin
              flag_q <= 1'b1;
              done_q <= 1'b1;
            end else begin
              // a is multiplier/dividend in the low accumulator half; b is multiplicand/divisor.
              flag_q   <= 1'b0;
              op_q     <= op;
              neg_lo_q <= a[WIDTH-1] ^ b[WIDTH-1];
              neg_hi_q <= a[WIDTH-1];
              acc_q    <= {{WIDTH{1'b0}}, mag_a};
              opnd_q   <= mag_b;
              rem_q    <= '0;
              cnt_q    <= CW'(WIDTH - 1);
              busy_q   <= 1'b1;
              state_q  <= (op == MD_DIV) ? MD_DIV_ST : MD_MULT_ST;
            end
          end
        end
        MD_MULT_ST: begin
          acc_q <= {mul_sum, acc_q[WIDTH-1:1]};
          cnt_q <= cnt_q - {{(CW-1){1'b0}}, 1'b1};
          if (cnt_q == '0) state_q <= MD_FIX;
        end
        MD_DIV_ST: begin
          rem_q <= div_trial[WIDTH] ? div_shift[WIDTH-1:0] : div_trial[WIDTH-1:0];
          acc_q[WIDTH-1:0] <= {acc_q[WIDTH-2:0], ~div_trial[WIDTH]};
          cnt_q <= cnt_q - {{(CW-1){1'b0}}, 1'b1};
          if (cnt_q == '0) state_q <= MD_FIX;
        end
        MD_FIX: begin
          hi_q    <= (op_q == MD_DIV) ? rem_fix : prod_hi_fix;
          lo_q    <= lo_fix;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= MD_IDLE;
        end
        default: state_q <= MD_IDLE;
      endcase
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign hi         = hi_q;
  assign lo         = lo_q;
  assign divby0flag = flag_q;

endmodule
